fetch_stage: RTL and testbench

- Instruction-fetch (F) stage of the 5-stage MIPS pipeline, together with the F/D pipeline register.
- Holds the PC and drives the instruction-memory address.
- Selects the next PC from four sources: sequential, branch/jump target, ERET return, or exception entry.
- Registers IR_D, PC4_D and EXC_D into the decode stage; decode returns the redirect controls (PC_sel, b_j_jr_tgt, ERET_PC_sel) to this block.

---
 rtl/fetch_stage.sv | 87 ++++++++
 tb/tb_fetch_stage.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with the F/D pipeline register: PC, next-PC selection,
// fetch-address checking and the registered hand-off to decode.
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_3000,
   parameter logic [31:0] EXC_PC    = 32'h0000_4180,
   parameter logic [31:0] IM_LO     = 32'h0000_3000,
   parameter logic [31:0] IM_HI     = 32'h0000_6FFC,
   parameter logic [4:0]  ADEL_CODE = 5'd4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        exc_req,
   input  logic        PC_sel,
   input  logic [31:0] b_j_jr_tgt,
   input  logic        ERET_PC_sel,
   input  logic [31:0] EPC,
   input  logic [31:0] im_rdata,
   output logic [31:0] im_addr,
   output logic [31:0] PC_F,
   output logic [31:0] IR_D,
   output logic [31:0] PC4_D,
   output logic [4:0]  EXC_D
);

   logic [31:0] pc_q, pc_d;
   logic [31:0] ir_q, ir_d;
   logic [31:0] pc4_q, pc4_d;
   logic [4:0]  exc_q, exc_d;

   logic [31:0] pc4_f;
   logic        adel_f;
   logic [31:0] ir_f;
   logic [4:0]  exc_f;

   assign pc4_f  = pc_q + 32'd4;
   assign adel_f = (pc_q[1:0] != 2'b00) || (pc_q < IM_LO) || (pc_q > IM_HI);
   assign ir_f   = adel_f ? '0 : im_rdata;
   assign exc_f  = adel_f ? ADEL_CODE : '0;

   // Exception beats stall; stall beats any decode redirect, which decode re-presents later.
   always_comb begin
      pc_d  = pc_q;
      ir_d  = ir_q;
      pc4_d = pc4_q;
      exc_d = exc_q;
      if (exc_req) begin
         pc_d  = EXC_PC;
         ir_d  = '0;
         pc4_d = EXC_PC;
         exc_d = '0;
      end else if (!stall) begin
         if (ERET_PC_sel) begin
            pc_d  = EPC;
            ir_d  = '0;
            pc4_d = EPC;
            exc_d = '0;
         end else begin
            pc_d  = PC_sel ? b_j_jr_tgt : pc4_f;
            ir_d  = ir_f;
            pc4_d = pc4_f;
            exc_d = exc_f;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q  <= RESET_PC;
         ir_q  <= '0;
         pc4_q <= '0;
         exc_q <= '0;
      end else begin
         pc_q  <= pc_d;
         ir_q  <= ir_d;
         pc4_q <= pc4_d;
         exc_q <= exc_d;
      end
   end

   assign im_addr = pc_q;
   assign PC_F    = pc_q;
   assign IR_D    = ir_q;
   assign PC4_D   = pc4_q;
   assign EXC_D   = exc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: vector table driven through an expectation queue.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall, exc_req, PC_sel, ERET_PC_sel;
   logic [31:0] b_j_jr_tgt, EPC;
   logic [31:0] im_rdata, im_addr, PC_F, IR_D, PC4_D;
   logic [4:0]  EXC_D;

   int unsigned total = 0;
   int unsigned bad   = 0;

   fetch_stage #(
      .RESET_PC (32'h0000_3000),
      .EXC_PC   (32'h0000_4180),
      .IM_LO    (32'h0000_3000),
      .IM_HI    (32'h0000_6FFC),
      .ADEL_CODE(5'd4)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .stall      (stall),
      .exc_req    (exc_req),
      .PC_sel     (PC_sel),
      .b_j_jr_tgt (b_j_jr_tgt),
      .ERET_PC_sel(ERET_PC_sel),
      .EPC        (EPC),
      .im_rdata   (im_rdata),
      .im_addr    (im_addr),
      .PC_F       (PC_F),
      .IR_D       (IR_D),
      .PC4_D      (PC4_D),
      .EXC_D      (EXC_D)
   );

   always #5 clk = ~clk;

   // Instruction memory model: each word is tagged with its own address.
   assign im_rdata = 32'hC000_0000 | im_addr;

   typedef struct {
      logic        st, ex, bj, er;
      logic [31:0] tgt, epc;
      logic [31:0] e_pc, e_ir, e_pc4;
      logic [4:0]  e_exc;
   } vec_t;

   typedef struct {
      int unsigned idx;
      logic [31:0] pc, ir, pc4;
      logic [4:0]  exc;
   } exp_t;

   vec_t vecs[22];
   exp_t sb[$];

   function automatic vec_t mk(input logic st, ex, bj, er, input logic [31:0] tgt, epc,
                               input logic [31:0] e_pc, e_ir, e_pc4, input logic [4:0] e_exc);
      vec_t v;
      v.st = st; v.ex = ex; v.bj = bj; v.er = er; v.tgt = tgt; v.epc = epc;
      v.e_pc = e_pc; v.e_ir = e_ir; v.e_pc4 = e_pc4; v.e_exc = e_exc;
      return v;
   endfunction

   function automatic logic [31:0] w(input logic [31:0] a);
      return 32'hC000_0000 | a;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic drive_idle();
      stall = 0; exc_req = 0; PC_sel = 0; ERET_PC_sel = 0;
      b_j_jr_tgt = '0; EPC = '0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      exp_t e;
      //          st ex bj er  tgt           epc           e_pc          e_ir           e_pc4         exc
      vecs[0]  = mk(0,0,0,0, 32'h0,        32'h0,        32'h3004,     w(32'h3000),   32'h3004,     5'd0);
      vecs[1]  = mk(0,0,0,0, 32'h0,        32'h0,        32'h3008,     w(32'h3004),   32'h3008,     5'd0);
      vecs[2]  = mk(0,0,1,0, 32'h3100,     32'h0,        32'h3100,     w(32'h3008),   32'h300C,     5'd0);
      vecs[3]  = mk(0,0,0,0, 32'h0,        32'h0,        32'h3104,     w(32'h3100),   32'h3104,     5'd0);
      vecs[4]  = mk(1,0,0,0, 32'h0,        32'h0,        32'h3104,     w(32'h3100),   32'h3104,     5'd0);
      vecs[5]  = mk(1,0,1,0, 32'h3500,     32'h0,        32'h3104,     w(32'h3100),   32'h3104,     5'd0);
      vecs[6]  = mk(0,0,0,0, 32'h0,        32'h0,        32'h3108,     w(32'h3104),   32'h3108,     5'd0);
      vecs[7]  = mk(0,0,1,1, 32'h3500,     32'h3204,     32'h3204,     32'h0,         32'h3204,     5'd0);
      vecs[8]  = mk(0,0,1,0, 32'h3002,     32'h0,        32'h3002,     w(32'h3204),   32'h3208,     5'd0);
      vecs[9]  = mk(0,0,0,0, 32'h0,        32'h0,        32'h3006,     32'h0,         32'h3006,     5'd4);
      vecs[10] = mk(0,0,1,0, 32'h7000,     32'h0,        32'h7000,     32'h0,         32'h300A,     5'd4);
      vecs[11] = mk(0,0,1,0, 32'h6FFC,     32'h0,        32'h6FFC,     32'h0,         32'h7004,     5'd4);
      vecs[12] = mk(0,0,0,0, 32'h0,        32'h0,        32'h7000,     w(32'h6FFC),   32'h7000,     5'd0);
      vecs[13] = mk(0,0,1,0, 32'h2FFC,     32'h0,        32'h2FFC,     32'h0,         32'h7004,     5'd4);
      vecs[14] = mk(0,0,1,0, 32'h3000,     32'h0,        32'h3000,     32'h0,         32'h3000,     5'd4);
      vecs[15] = mk(0,0,0,0, 32'h0,        32'h0,        32'h3004,     w(32'h3000),   32'h3004,     5'd0);
      vecs[16] = mk(1,1,0,0, 32'h0,        32'h0,        32'h4180,     32'h0,         32'h4180,     5'd0);
      vecs[17] = mk(0,0,0,0, 32'h0,        32'h0,        32'h4184,     w(32'h4180),   32'h4184,     5'd0);
      vecs[18] = mk(0,1,1,1, 32'h3300,     32'h3400,     32'h4180,     32'h0,         32'h4180,     5'd0);
      vecs[19] = mk(0,0,1,0, 32'hFFFF_FFFC, 32'h0,       32'hFFFF_FFFC, w(32'h4180),  32'h4184,     5'd0);
      vecs[20] = mk(0,0,0,0, 32'h0,        32'h0,        32'h0000_0000, 32'h0,        32'h0000_0000, 5'd4);
      vecs[21] = mk(0,0,0,0, 32'h0,        32'h0,        32'h0000_0004, 32'h0,        32'h0000_0004, 5'd4);

      drive_idle();
      reset = 1'b1;
      #1;
      chk("rst_pc",   PC_F,    32'h3000);
      chk("rst_addr", im_addr, 32'h3000);
      chk("rst_ir",   IR_D,    32'h0);
      chk("rst_pc4",  PC4_D,   32'h0);
      chk("rst_exc",  {27'd0, EXC_D}, 32'h0);

      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 22; i++) begin
         stall = vecs[i].st; exc_req = vecs[i].ex; PC_sel = vecs[i].bj; ERET_PC_sel = vecs[i].er;
         b_j_jr_tgt = vecs[i].tgt; EPC = vecs[i].epc;
         e.idx = i; e.pc = vecs[i].e_pc; e.ir = vecs[i].e_ir; e.pc4 = vecs[i].e_pc4; e.exc = vecs[i].e_exc;
         sb.push_back(e);
         @(posedge clk);
         #1;
         if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL scoreboard_empty actual=0 required=1");
         end else begin
            e = sb.pop_front();
            chk($sformatf("v%0d_pc",   e.idx), PC_F,  e.pc);
            chk($sformatf("v%0d_addr", e.idx), im_addr, e.pc);
            chk($sformatf("v%0d_ir",   e.idx), IR_D,  e.ir);
            chk($sformatf("v%0d_pc4",  e.idx), PC4_D, e.pc4);
            chk($sformatf("v%0d_exc",  e.idx), {27'd0, EXC_D}, {27'd0, e.exc});
         end
         @(negedge clk);
      end
      drive_idle();

      // Asynchronous reset between edges must take effect before the next rising edge.
      #2;
      reset = 1'b1;
      #1;
      chk("async_pc",  PC_F,  32'h3000);
      chk("async_ir",  IR_D,  32'h0);
      chk("async_pc4", PC4_D, 32'h0);
      chk("async_exc", {27'd0, EXC_D}, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk("post_rst_pc",  PC_F,  32'h3004);
      chk("post_rst_ir",  IR_D,  w(32'h3000));
      chk("post_rst_pc4", PC4_D, 32'h3004);

      // Stall held across several edges keeps everything frozen, then resumes sequentially.
      @(negedge clk);
      stall = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("stall3_pc", PC_F,  32'h3004);
      chk("stall3_ir", IR_D,  w(32'h3000));
      @(negedge clk);
      stall = 1'b0;
      @(posedge clk);
      #1;
      chk("unstall_pc", PC_F,  32'h3008);
      chk("unstall_ir", IR_D,  w(32'h3004));

      chk("sb_drained", sb.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
